// File: rtl/divisor_secuencial.sv
// Multicycle unsigned restoring divider: one trial subtraction per cycle through
// a resta instance, quotient bit taken from its N (borrow) flag.

module resta #(
    parameter int w = 9
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic [w-1:0] diferencia,
    output logic         neg
);
    assign {neg, diferencia} = {1'b0, a} - {1'b0, b};
endmodule

module divisor_secuencial #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] cociente,
    output logic [n-1:0] residuo,
    output logic         ocupado,
    output logic         listo,
    output logic         div_cero
);
    localparam int cw = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state, state_next;
    logic [n:0]      r, d, s, dif, r_next;
    logic [n-1:0]    q, q_next;
    logic [cw-1:0]   cnt;
    logic            neg;
    logic            ultimo;
    logic            unused_msb;

    // The restored remainder is always below the divisor, so R[n] never
    // reaches the next trial value; it is kept only for the n+1-bit datapath.
    assign unused_msb = r[n];

    assign s      = {r[n-1:0], q[n-1]};
    assign r_next = neg ? s : dif;
    assign q_next = {q[n-2:0], ~neg};
    assign ultimo = (cnt == cw'(1));

    resta #(.w(n + 1)) u_resta (
        .a          (s),
        .b          (d),
        .diferencia (dif),
        .neg        (neg)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (inicio) state_next = (b == '0) ? FIN : CALC;
            CALC:    if (ultimo) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r        <= '0;
            d        <= '0;
            q        <= '0;
            cnt      <= '0;
            cociente <= '0;
            residuo  <= '0;
            div_cero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (inicio) begin
                    if (b == '0) begin
                        cociente <= '1;
                        residuo  <= a;
                        div_cero <= 1'b1;
                    end else begin
                        r        <= '0;
                        q        <= a;
                        d        <= {1'b0, b};
                        cnt      <= cw'(n);
                        div_cero <= 1'b0;
                    end
                end
                CALC: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - cw'(1);
                    if (ultimo) begin
                        cociente <= q_next;
                        residuo  <= r_next[n-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocupado = (state == CALC);
    assign listo   = (state == FIN);
endmodule

// File: tb/tb_divisor_secuencial.sv
// Randomized scoreboard bench for divisor_secuencial: a driver pushes the
// arithmetic expectation of each accepted start, a monitor checks every listo.

module tb_divisor_secuencial;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         inicio;
    logic [N-1:0] a, b;
    logic [N-1:0] cociente, residuo;
    logic         ocupado, listo, div_cero;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           busy;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    divisor_secuencial #(.n(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .inicio   (inicio),
        .a        (a),
        .b        (b),
        .cociente (cociente),
        .residuo  (residuo),
        .ocupado  (ocupado),
        .listo    (listo),
        .div_cero (div_cero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic exp_t model(input int unsigned x, input int unsigned y);
        exp_t e;
        if (y == 0) begin
            e.q = '1; e.r = N'(x); e.dz = 1'b1; e.busy = 0;
        end else begin
            e.q = N'(x / y); e.r = N'(x % y); e.dz = 1'b0; e.busy = N;
        end
        return e;
    endfunction

    // Monitor: counts ocupado cycles and checks each listo against the scoreboard.
    initial begin
        int busy_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (ocupado) busy_cnt++;
                if (listo) begin
                    if (sb.size() == 0) begin
                        check("spurious_listo", 32'(listo), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("cociente", 32'(cociente), 32'(e.q));
                        check("residuo", 32'(residuo), 32'(e.r));
                        check("div_cero", 32'(div_cero), 32'(e.dz));
                        check("ocupado_cycles", 32'(busy_cnt), 32'(e.busy));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Issue one start; inj >= 0 drives an extra 9/4 request while busy.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input int gap, input int inj);
        exp_t e;
        bit   done = 1'b0;
        repeat (gap) @(negedge clk);
        a = x; b = y; inicio = 1'b1;
        e = model(x, y);
        sb.push_back(e);
        @(negedge clk);
        for (int i = 0; i < 40 && !done; i++) begin
            inicio = 1'b0;
            if (listo) begin
                done = 1'b1;
            end else begin
                if (i == inj) begin
                    a = 8'd9; b = 8'd4; inicio = 1'b1;
                end else begin
                    a = N'($urandom); b = N'($urandom);
                end
                @(negedge clk);
            end
        end
        inicio = 1'b0;
        if (!done) check("listo_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("listo_pulse_width", 32'(listo), 32'd0);
        check("div_cero_hold", 32'(div_cero), 32'(e.dz));
        check("cociente_hold", 32'(cociente), 32'(e.q));
    endtask

    initial begin
        rst = 1'b1; inicio = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_cociente", 32'(cociente), 32'd0);
        check("rst_residuo", 32'(residuo), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_listo", 32'(listo), 32'd0);
        check("rst_div_cero", 32'(div_cero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd100, 8'd7, 0, -1);
        run_op(8'd255, 8'd1, 1, -1);
        run_op(8'd255, 8'd255, 0, -1);
        run_op(8'd5, 8'd9, 2, -1);
        run_op(8'd42, 8'd0, 0, -1);
        run_op(8'd200, 8'd3, 0, 2);

        // Abort 100/7 during its fourth iteration.
        a = 8'd100; b = 8'd7; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_cociente", 32'(cociente), 32'd0);
        check("abort_residuo", 32'(residuo), 32'd0);
        check("abort_ocupado", 32'(ocupado), 32'd0);
        check("abort_listo", 32'(listo), 32'd0);
        check("abort_div_cero", 32'(div_cero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_op(8'd100, 8'd7, 0, -1);

        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] x, y;
            x = N'($urandom);
            case ($urandom_range(0, 5))
                0:       y = '0;
                1:       y = N'($urandom_range(1, 4));
                default: y = N'($urandom_range(1, 255));
            endcase
            run_op(x, y, $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 2) : -1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
